// File: rtl/mem_access_unit_if.sv
// Memory-side request/ack bus between the access unit (master) and data memory (slave).
interface mem_access_unit_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sizing, big-endian lane steering and req/ack sequencing for the data memory.
// Latency: issue cycle + REQ cycles until m_ack (or TIMEOUT) + one DONE cycle; stall holds the datapath until DONE.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout_err,
  mem_access_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] size;
    logic       sign_ext;
  } ld_ctx_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  ld_ctx_t     ld_ctx;
  logic [7:0]  tmo_cnt;
  logic [31:0] rdata_q;

  logic        op;
  logic        aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign op = mem_read | mem_write;

  always_comb begin
    aligned = 1'b1;
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign misalign = (state == IDLE) && op && !aligned;
  assign stall    = ((state == IDLE) && op && aligned) || (state == REQ);
  // A misaligned access retires in its own cycle, so zero is forced before the register catches up.
  assign rdata    = misalign ? 32'h0 : rdata_q;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (size)
      2'b00: begin
        st_be    = 4'b1000 >> addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = addr[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem.m_rdata[7:0];
    case (ld_ctx.lane)
      2'd0:    ld_byte = mem.m_rdata[31:24];
      2'd1:    ld_byte = mem.m_rdata[23:16];
      2'd2:    ld_byte = mem.m_rdata[15:8];
      default: ld_byte = mem.m_rdata[7:0];
    endcase
    ld_half = ld_ctx.lane[1] ? mem.m_rdata[15:0] : mem.m_rdata[31:16];
    case (ld_ctx.size)
      2'b00:   ld_data = {{24{ld_ctx.sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_ctx.sign_ext & ld_half[15]}}, ld_half};
      default: ld_data = mem.m_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      ld_ctx      <= '0;
      tmo_cnt     <= 8'h0;
      rdata_q     <= 32'h0;
      timeout_err <= 1'b0;
      mem.m_req   <= 1'b0;
      mem.m_we    <= 1'b0;
      mem.m_addr  <= 32'h0;
      mem.m_wdata <= 32'h0;
      mem.m_be    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= 8'h0;
          if (op && aligned) begin
            state       <= REQ;
            mem.m_req   <= 1'b1;
            // Write wins when both strobes are set.
            mem.m_we    <= mem_write;
            mem.m_addr  <= {addr[31:2], 2'b00};
            mem.m_wdata <= st_wdata;
            mem.m_be    <= mem_write ? st_be : 4'b0000;
            ld_ctx      <= '{lane: addr[1:0], size: size, sign_ext: sign_ext};
          end else if (op) begin
            rdata_q <= 32'h0;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem.m_ack) begin
            if (!mem.m_we) rdata_q <= ld_data;
            mem.m_req <= 1'b0;
            mem.m_be  <= 4'h0;
            state     <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem.m_req   <= 1'b0;
            timeout_err <= 1'b1;
            rdata_q     <= 32'h0;
            state       <= DONE;
          end
        end
        DONE: begin
          tmo_cnt <= 8'h0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-arithmetic reference model of sizing and lanes.
module tb_mem_access_unit;
  logic        clk;
  logic        arst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_rdata = 32'h0;
  logic        model_terr  = 1'b0;

  mem_access_unit_if mif();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .arst        (arst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .sign_ext    (sign_ext),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .misalign    (misalign),
    .timeout_err (timeout_err),
    .mem         (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_load(logic [1:0] sz, bit sx, logic [31:0] a, logic [31:0] w);
    int unsigned off = a % 4;
    logic [31:0] v;
    case (sz)
      2'b00: begin
        v = (w >> ((3 - off) * 8)) & 32'hFF;
        if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (w >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
        if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(bit we, logic [1:0] sz, logic [31:0] a);
    int unsigned off = a % 4;
    if (!we) return 4'h0;
    case (sz)
      2'b00:   return 4'(1 << (3 - off));
      2'b01:   return (off >= 2) ? 4'h3 : 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] sz, logic [31:0] w);
    case (sz)
      2'b00:   return (w & 32'hFF) * 32'h0101_0101;
      2'b01:   return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic drive_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    size      = 2'b00;
    sign_ext  = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with spurious acks; nothing may move.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      drive_idle();
      mif.m_ack   = 1'($urandom_range(0, 1));
      mif.m_rdata = $urandom;
      #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL idle stall: got %b want 0", stall); else n_pass++;
      n_checks++; if (mif.m_req !== 1'b0) $display("FAIL idle m_req: got %b want 0", mif.m_req); else n_pass++;
      n_checks++; if (rdata !== model_rdata) $display("FAIL idle rdata: got %h want %h", rdata, model_rdata); else n_pass++;
      n_checks++; if (timeout_err !== model_terr) $display("FAIL idle timeout_err: got %b want %b", timeout_err, model_terr); else n_pass++;
    end
    mif.m_ack = 1'b0;
  endtask

  // One aligned access; memory acks in REQ cycle number `delay`. Leaves inputs held through DONE.
  task automatic run_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                            input logic [31:0] a, input logic [31:0] w, input logic [31:0] rword,
                            input int delay, input string tag);
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    e_addr = a & 32'hFFFF_FFFC;
    e_be   = exp_be(wr, sz, a);
    next_cycle();
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; addr = a; wdata = w;
    mif.m_ack = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL %s issue stall: got %b want 1", tag, stall); else n_pass++;
    n_checks++; if (misalign !== 1'b0) $display("FAIL %s issue misalign: got %b want 0", tag, misalign); else n_pass++;
    for (int c = 1; c <= delay; c++) begin
      next_cycle();
      mif.m_ack   = (c == delay);
      mif.m_rdata = (c == delay) ? rword : $urandom;
      #1;
      n_checks++; if (mif.m_req !== 1'b1) $display("FAIL %s req m_req c%0d: got %b want 1", tag, c, mif.m_req); else n_pass++;
      n_checks++; if (stall !== 1'b1) $display("FAIL %s req stall c%0d: got %b want 1", tag, c, stall); else n_pass++;
      n_checks++; if (mif.m_we !== wr) $display("FAIL %s m_we: got %b want %b", tag, mif.m_we, wr); else n_pass++;
      n_checks++; if (mif.m_addr !== e_addr) $display("FAIL %s m_addr: got %h want %h", tag, mif.m_addr, e_addr); else n_pass++;
      n_checks++; if (mif.m_be !== e_be) $display("FAIL %s m_be: got %b want %b", tag, mif.m_be, e_be); else n_pass++;
      if (wr) begin
        n_checks++;
        if (mif.m_wdata !== exp_wdata(sz, w)) $display("FAIL %s m_wdata: got %h want %h", tag, mif.m_wdata, exp_wdata(sz, w));
        else n_pass++;
      end
    end
    next_cycle();
    mif.m_ack   = 1'b0;
    mif.m_rdata = $urandom;
    #1;
    if (rd && !wr) model_rdata = exp_load(sz, sx, a, rword);
    n_checks++; if (stall !== 1'b0) $display("FAIL %s done stall: got %b want 0", tag, stall); else n_pass++;
    n_checks++; if (mif.m_req !== 1'b0) $display("FAIL %s done m_req: got %b want 0", tag, mif.m_req); else n_pass++;
    n_checks++; if (mif.m_be !== 4'h0) $display("FAIL %s done m_be: got %b want 0000", tag, mif.m_be); else n_pass++;
    n_checks++; if (rdata !== model_rdata) $display("FAIL %s done rdata: got %h want %h", tag, rdata, model_rdata); else n_pass++;
  endtask

  task automatic test_reset();
    drive_idle();
    mif.m_ack = 1'b0; mif.m_rdata = 32'h0;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mif.m_req !== 1'b0) $display("FAIL reset m_req: got %b want 0", mif.m_req); else n_pass++;
    n_checks++; if (mif.m_we !== 1'b0) $display("FAIL reset m_we: got %b want 0", mif.m_we); else n_pass++;
    n_checks++; if (mif.m_addr !== 32'h0) $display("FAIL reset m_addr: got %h want 0", mif.m_addr); else n_pass++;
    n_checks++; if (mif.m_wdata !== 32'h0) $display("FAIL reset m_wdata: got %h want 0", mif.m_wdata); else n_pass++;
    n_checks++; if (mif.m_be !== 4'h0) $display("FAIL reset m_be: got %b want 0", mif.m_be); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset timeout_err: got %b want 0", timeout_err); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset stall: got %b want 0", stall); else n_pass++;
    arst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_lw();
    run_access(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, "lw");
    n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL lw rdata: got %h want deadbeef", rdata); else n_pass++;
    idle_cycles(1);
  endtask

  task automatic test_lb();
    run_access(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h1122_33F0, 2, "lb_sx");
    n_checks++; if (rdata !== 32'hFFFF_FFF0) $display("FAIL lb_sx rdata: got %h want fffffff0", rdata); else n_pass++;
    run_access(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h1122_33F0, 1, "lb_zx");
    n_checks++; if (rdata !== 32'h0000_00F0) $display("FAIL lb_zx rdata: got %h want 000000f0", rdata); else n_pass++;
    idle_cycles(1);
  endtask

  task automatic test_sh();
    run_access(0, 1, 2'b01, 0, 32'h22, 32'h0000_ABCD, $urandom, 2, "sh");
    idle_cycles(2);
  endtask

  task automatic test_misalign();
    next_cycle();
    mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h06;
    #1;
    model_rdata = 32'h0;
    n_checks++; if (misalign !== 1'b1) $display("FAIL mis_lw misalign: got %b want 1", misalign); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL mis_lw stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL mis_lw rdata: got %h want 0", rdata); else n_pass++;
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b1; size = 2'b01; addr = 32'h11;
    #1;
    n_checks++; if (misalign !== 1'b1) $display("FAIL mis_sh misalign: got %b want 1", misalign); else n_pass++;
    n_checks++; if (mif.m_req !== 1'b0) $display("FAIL mis_sh m_req: got %b want 0", mif.m_req); else n_pass++;
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [1:0] sz;
      logic [31:0] a;
      k  = $urandom_range(1, 3);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
      else if (sz != 2'b00) a = a & 32'hFFFF_FFFC;
      run_access(1'(k % 2), 1'(k / 2), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                 $urandom_range(1, 3), "rnd");
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    run_access(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 32'h1234_8765, 1, "b2b_lh");
    run_access(0, 1, 2'b00, 0, 32'h0000_0201, 32'h0000_005A, $urandom, 1, "b2b_sb");
    run_access(1, 1, 2'b10, 0, 32'h0000_0300, 32'hCAFE_F00D, $urandom, 2, "b2b_both");
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    next_cycle();
    mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h40;
    mif.m_ack = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL tmo issue stall: got %b want 1", stall); else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      #1;
      n_checks++; if (mif.m_req !== 1'b1) $display("FAIL tmo m_req c%0d: got %b want 1", c, mif.m_req); else n_pass++;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL tmo early err c%0d: got %b want 0", c, timeout_err); else n_pass++;
    end
    next_cycle();
    #1;
    model_terr = 1'b1; model_rdata = 32'h0;
    n_checks++; if (mif.m_req !== 1'b0) $display("FAIL tmo done m_req: got %b want 0", mif.m_req); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo err: got %b want 1", timeout_err); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL tmo rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL tmo stall: got %b want 0", stall); else n_pass++;
    next_cycle();
    drive_idle();
    mif.m_ack = 1'b1; mif.m_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (mif.m_req !== 1'b0) $display("FAIL tmo late ack m_req: got %b want 0", mif.m_req); else n_pass++;
    idle_cycles(2);
    run_access(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0BAD_C0DE, 3, "post_tmo");
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo sticky: got %b want 1", timeout_err); else n_pass++;
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_req();
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b1; size = 2'b10; addr = 32'h80; wdata = $urandom;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL rst_req issue stall: got %b want 1", stall); else n_pass++;
    next_cycle();
    #1;
    n_checks++; if (mif.m_req !== 1'b1) $display("FAIL rst_req m_req: got %b want 1", mif.m_req); else n_pass++;
    next_cycle();
    arst = 1'b1;
    drive_idle();
    #1;
    model_rdata = 32'h0; model_terr = 1'b0;
    n_checks++; if (mif.m_req !== 1'b0) $display("FAIL rst_req m_req drop: got %b want 0", mif.m_req); else n_pass++;
    n_checks++; if (mif.m_we !== 1'b0) $display("FAIL rst_req m_we: got %b want 0", mif.m_we); else n_pass++;
    n_checks++; if (mif.m_addr !== 32'h0) $display("FAIL rst_req m_addr: got %h want 0", mif.m_addr); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_req timeout_err: got %b want 0", timeout_err); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_req stall: got %b want 0", stall); else n_pass++;
    next_cycle();
    arst = 1'b0;
    mif.m_ack = 1'b1; mif.m_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (rdata !== 32'h0) $display("FAIL rst_req ack rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if (mif.m_be !== 4'h0) $display("FAIL rst_req ack m_be: got %b want 0", mif.m_be); else n_pass++;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_misalign();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
